// File: rtl/seg_pkg.sv
// Shared glyph constants, FSM states and decimal range helper for the segment encoder.
package seg_pkg;

   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_A     = 8'h77;
   localparam logic [7:0] SEG_B     = 8'h7C;
   localparam logic [7:0] SEG_C     = 8'h39;
   localparam logic [7:0] SEG_D     = 8'h5E;
   localparam logic [7:0] SEG_E     = 8'h79;
   localparam logic [7:0] SEG_F     = 8'h71;
   localparam logic [7:0] SEG_DASH  = 8'h40;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } seg_state_e;

   // Largest value representable on n decimal digits (10^n - 1).
   function automatic longint unsigned seg_max_dec(input int unsigned n);
      longint unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) begin
         r = r * 10;
      end
      return r - 1;
   endfunction

endpackage

// File: rtl/seg_glyph_lut.sv
// Nibble to active-high 7-segment glyph (bit0=a .. bit6=g).
// Hex glyphs A..F exist only when SEG_BIN_ENCODER_HEX_EN is defined.
module seg_glyph_lut
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] glyph_o
);

   always_comb begin
      glyph_o = SEG_BLANK[6:0];
      case (nib_i)
         4'h0: glyph_o = SEG_0[6:0];
         4'h1: glyph_o = SEG_1[6:0];
         4'h2: glyph_o = SEG_2[6:0];
         4'h3: glyph_o = SEG_3[6:0];
         4'h4: glyph_o = SEG_4[6:0];
         4'h5: glyph_o = SEG_5[6:0];
         4'h6: glyph_o = SEG_6[6:0];
         4'h7: glyph_o = SEG_7[6:0];
         4'h8: glyph_o = SEG_8[6:0];
         4'h9: glyph_o = SEG_9[6:0];
`ifdef SEG_BIN_ENCODER_HEX_EN
         4'hA: glyph_o = SEG_A[6:0];
         4'hB: glyph_o = SEG_B[6:0];
         4'hC: glyph_o = SEG_C[6:0];
         4'hD: glyph_o = SEG_D[6:0];
         4'hE: glyph_o = SEG_E[6:0];
         4'hF: glyph_o = SEG_F[6:0];
`endif
         default: glyph_o = SEG_BLANK[6:0];
      endcase
   end

endmodule

// File: rtl/seg_bin_encoder.sv
// Binary to 7-segment encoder: valid/ready accept, sequential double-dabble, registered glyph outputs.
// Optional hex display mode enabled by SEG_BIN_ENCODER_HEX_EN.
module seg_bin_encoder
   import seg_pkg::*;
#(
   parameter int unsigned NDigits  = 8,
   parameter int unsigned BinWidth = 27
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [BinWidth-1:0]    bin_i,
   input  logic [NDigits-1:0]     dp_i,
   input  logic                   blank_lz_i,
   input  logic                   bin_valid_i,
`ifdef SEG_BIN_ENCODER_HEX_EN
   input  logic                   hex_mode_i,
`endif
   output logic                   bin_ready_o,
   output logic [NDigits-1:0]     valid_o,
   output logic [NDigits*8-1:0]   seg_o,
   output logic                   ovf_o,
   output logic                   done_o
);

   localparam int unsigned BcdW = 4 * NDigits;
   localparam int unsigned CntW = (BinWidth > 1) ? $clog2(BinWidth) : 1;

   seg_state_e            state_q, state_d;
   logic [BinWidth-1:0]   bin_q, bin_d;
   logic [BcdW-1:0]       bcd_q, bcd_d;
   logic                  carry_q, carry_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [NDigits-1:0]    dp_q, dp_d;
   logic                  blank_q, blank_d;
   logic [NDigits-1:0]    valid_q, valid_d;
   logic [NDigits*8-1:0]  seg_q, seg_d;
   logic                  ovf_q, ovf_d;
   logic                  done_q, done_d;

   logic [BcdW-1:0]       bcd_adj;
   logic [BcdW-1:0]       disp_nib;
   logic                  disp_ovf;
   logic [NDigits*7-1:0]  glyph;
   logic [NDigits-1:0]    lead_zero;

   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned k = 0; k < NDigits; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) begin
            bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         end
      end
   end

`ifdef SEG_BIN_ENCODER_HEX_EN
   localparam int unsigned ExtW = (BinWidth > BcdW) ? BinWidth : BcdW;

   logic            hex_q, hex_d;
   logic [ExtW-1:0] bin_ext;

   assign bin_ext  = ExtW'(bin_q);
   assign disp_nib = hex_q ? bin_ext[BcdW-1:0] : bcd_q;
   assign disp_ovf = hex_q ? (|(bin_ext >> BcdW)) : carry_q;
`else
   assign disp_nib = bcd_q;
   assign disp_ovf = carry_q;
`endif

   for (genvar g = 0; g < NDigits; g++) begin : g_lut
      seg_glyph_lut u_lut (
         .nib_i   (disp_nib[4*g +: 4]),
         .glyph_o (glyph[7*g +: 7])
      );
   end

   // Digit k is a leading zero when it and every digit above it are zero; digit 0 never is.
   always_comb begin
      logic zero_above;
      int unsigned k;
      zero_above = 1'b1;
      lead_zero  = '0;
      for (int unsigned i = 0; i < NDigits; i++) begin
         k = NDigits - 1 - i;
         zero_above   = zero_above && (disp_nib[4*k +: 4] == 4'd0);
         lead_zero[k] = zero_above && (k != 0);
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      dp_d    = dp_q;
      blank_d = blank_q;
      valid_d = valid_q;
      seg_d   = seg_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
`ifdef SEG_BIN_ENCODER_HEX_EN
      hex_d   = hex_q;
`endif
      case (state_q)
         IDLE: begin
            if (bin_valid_i) begin
               bin_d   = bin_i;
               dp_d    = dp_i;
               blank_d = blank_lz_i;
               bcd_d   = '0;
               carry_d = 1'b0;
               cnt_d   = '0;
               state_d = SHIFT;
`ifdef SEG_BIN_ENCODER_HEX_EN
               hex_d   = hex_mode_i;
               if (hex_mode_i) begin
                  state_d = LOAD;
               end
`endif
            end
         end
         SHIFT: begin
            // A bit leaving the top nibble means the value no longer fits: keep it sticky.
            bcd_d   = {bcd_adj[BcdW-2:0], bin_q[BinWidth-1]};
            bin_d   = bin_q << 1;
            carry_d = carry_q | bcd_adj[BcdW-1];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntW'(BinWidth - 1)) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            done_d  = 1'b1;
            ovf_d   = disp_ovf;
            state_d = IDLE;
            if (disp_ovf) begin
               valid_d = '1;
               seg_d   = {NDigits{SEG_DASH}};
            end else begin
               for (int unsigned k = 0; k < NDigits; k++) begin
                  if (blank_q && lead_zero[k]) begin
                     valid_d[k]       = 1'b0;
                     seg_d[8*k +: 8]  = SEG_BLANK;
                  end else begin
                     valid_d[k]       = 1'b1;
                     seg_d[8*k +: 8]  = {dp_q[k], glyph[7*k +: 7]};
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         dp_q    <= '0;
         blank_q <= 1'b0;
         valid_q <= '0;
         seg_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef SEG_BIN_ENCODER_HEX_EN
         hex_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         dp_q    <= dp_d;
         blank_q <= blank_d;
         valid_q <= valid_d;
         seg_q   <= seg_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
`ifdef SEG_BIN_ENCODER_HEX_EN
         hex_q   <= hex_d;
`endif
      end
   end

   assign bin_ready_o = (state_q == IDLE);
   assign valid_o     = valid_q;
   assign seg_o       = seg_q;
   assign ovf_o       = ovf_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_seg_bin_encoder.sv
// Scoreboard bench for seg_bin_encoder: random and directed requests against a digit-arithmetic model.
module tb_seg_bin_encoder;

   localparam int unsigned N  = 8;
   localparam int unsigned BW = 27;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [BW-1:0]     bin_i = '0;
   logic [N-1:0]      dp_i = '0;
   logic              blank_lz_i = 1'b0;
   logic              bin_valid_i = 1'b0;
`ifdef SEG_BIN_ENCODER_HEX_EN
   logic              hex_mode_i = 1'b0;
`endif
   logic              bin_ready_o;
   logic [N-1:0]      valid_o;
   logic [N*8-1:0]    seg_o;
   logic              ovf_o;
   logic              done_o;

   seg_bin_encoder #(.NDigits(N), .BinWidth(BW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bin_i       (bin_i),
      .dp_i        (dp_i),
      .blank_lz_i  (blank_lz_i),
      .bin_valid_i (bin_valid_i),
`ifdef SEG_BIN_ENCODER_HEX_EN
      .hex_mode_i  (hex_mode_i),
`endif
      .bin_ready_o (bin_ready_o),
      .valid_o     (valid_o),
      .seg_o       (seg_o),
      .ovf_o       (ovf_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]   valid;
      logic [N*8-1:0] seg;
      logic           ovf;
      int unsigned    due;
   } exp_t;

   exp_t          sb[$];
   int unsigned   errors = 0;
   int unsigned   checks = 0;
   int unsigned   cyc = 0;
   logic [7:0]    glyph_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                     8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: split the value into base-10 (or base-16) digits arithmetically.
   function automatic exp_t model(input longint unsigned v, input logic [N-1:0] dp,
                                  input logic blank, input logic hex);
      exp_t            e;
      longint unsigned base, lim, p;
      int unsigned     d [N];
      int unsigned     msd;
      base = hex ? 16 : 10;
      lim  = 1;
      for (int unsigned i = 0; i < N; i++) lim = lim * base;
      e.ovf   = (v >= lim);
      e.valid = '0;
      e.seg   = '0;
      e.due   = 0;
      if (e.ovf) begin
         e.valid = '1;
         for (int unsigned k = 0; k < N; k++) e.seg[8*k +: 8] = 8'h40;
         return e;
      end
      p   = 1;
      msd = 0;
      for (int unsigned k = 0; k < N; k++) begin
         d[k] = int'((v / p) % base);
         if (d[k] != 0) msd = k;
         p = p * base;
      end
      for (int unsigned k = 0; k < N; k++) begin
         if (blank && k > msd) begin
            e.valid[k] = 1'b0;
         end else begin
            e.valid[k]       = 1'b1;
            e.seg[8*k +: 8]  = {dp[k], glyph_tab[d[k]][6:0]};
         end
      end
      return e;
   endfunction

   task automatic push_exp(input longint unsigned v, input logic [N-1:0] dp,
                           input logic blank, input logic hex);
      exp_t e;
      e     = model(v, dp, blank, hex);
      e.due = cyc + 1 + (hex ? 1 : BW + 1);
      sb.push_back(e);
   endtask

   task automatic send(input longint unsigned v, input logic [N-1:0] dp,
                       input logic blank, input logic hex);
      int unsigned w;
      @(negedge clk);
      bin_i       = BW'(v);
      dp_i        = dp;
      blank_lz_i  = blank;
`ifdef SEG_BIN_ENCODER_HEX_EN
      hex_mode_i  = hex;
`endif
      bin_valid_i = 1'b1;
      w = 0;
      while (!bin_ready_o && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!bin_ready_o) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: ready=%b expected 1", bin_ready_o);
      end else begin
         push_exp(v, dp, blank, hex);
      end
      @(posedge clk);
      #1;
      bin_valid_i = 1'b0;
      bin_i       = BW'($urandom);
   endtask

   // Request held high while busy; the input changes every cycle.
   task automatic burst(input int unsigned count);
      int unsigned acc, w;
      acc = 0;
      w   = 0;
      @(negedge clk);
      bin_valid_i = 1'b1;
`ifdef SEG_BIN_ENCODER_HEX_EN
      hex_mode_i  = 1'b0;
`endif
      while (acc < count && w < count * 60) begin
         bin_i      = BW'($urandom_range(0, 99999999));
         dp_i       = N'($urandom);
         blank_lz_i = 1'($urandom);
         if (bin_ready_o) begin
            push_exp(longint'(bin_i), dp_i, blank_lz_i, 1'b0);
            acc++;
         end
         @(negedge clk);
         w++;
      end
      bin_valid_i = 1'b0;
      check("burst_accepts", 64'(acc), 64'(count));
   endtask

   task automatic drain();
      int unsigned w;
      w = 0;
      while (sb.size() != 0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: pops on done_o, otherwise requires the outputs to hold.
   initial begin
      logic [N-1:0]   pv;
      logic [N*8-1:0] ps;
      logic           po;
      exp_t           e;
      pv = '0; ps = '0; po = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = '0; ps = '0; po = 1'b0;
         end else if (done_o) begin
            check("ready_with_done", 64'(bin_ready_o), 64'd1);
            if (sb.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("valid_o", 64'(valid_o), 64'(e.valid));
               check("seg_o", 64'(seg_o), 64'(e.seg));
               check("ovf_o", 64'(ovf_o), 64'(e.ovf));
               check("latency", 64'(cyc), 64'(e.due));
            end
            pv = valid_o; ps = seg_o; po = ovf_o;
         end else begin
            check("hold", {55'(seg_o[N*8-1:8] ^ ps[N*8-1:8]), valid_o, ovf_o},
                          {55'd0, pv, po});
            check("hold_seg0", 64'(seg_o[7:0]), 64'(ps[7:0]));
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(bin_ready_o), 64'd1);
      check("rst_valid", 64'(valid_o), 64'd0);
      check("rst_seg", 64'(seg_o), 64'd0);
      check("rst_ovf", 64'(ovf_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      #1 rst = 1'b0;

      send(12345678, 8'h04, 1'b0, 1'b0);
      send(0, 8'h00, 1'b1, 1'b0);
      send(0, 8'hFF, 1'b0, 1'b0);
      send(100000000, 8'hFF, 1'b0, 1'b0);
      send(7, 8'h00, 1'b0, 1'b0);
      send(99999999, 8'h81, 1'b1, 1'b0);
      send(10, 8'h03, 1'b1, 1'b0);
      send((1 << BW) - 1, 8'h00, 1'b1, 1'b0);
      send(5, 8'h10, 1'b1, 1'b0);
      for (int i = 0; i < 30; i++) begin
         if (i % 2 == 0) send($urandom_range(0, 9999), N'($urandom), 1'($urandom), 1'b0);
         else            send(longint'(BW'($urandom)), N'($urandom), 1'($urandom), 1'b0);
      end
      burst(5);
`ifdef SEG_BIN_ENCODER_HEX_EN
      send(27'h0ABCDEF, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         send(longint'(BW'($urandom)), N'($urandom), 1'($urandom), 1'b1);
      end
      send(3, 8'h00, 1'b0, 1'b0);
`endif
      drain();

      send(54321, 8'h00, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_valid", 64'(valid_o), 64'd0);
      check("midrst_seg", 64'(seg_o), 64'd0);
      check("midrst_ready", 64'(bin_ready_o), 64'd1);
      check("midrst_done", 64'(done_o), 64'd0);
      sb.delete();
      #1 rst = 1'b0;
      repeat (BW + 4) @(negedge clk);
      send(42, 8'h02, 1'b1, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
